// File: rtl/vproc_hazard_tracker.sv
// Vector register scoreboard: tracks pending writes and in-flight reader counts
// per vreg, and gates instruction issue on RAW/WAW/WAR hazards and reader-counter saturation.

module vproc_hazard_rd_cnt #(
  parameter int unsigned RD_CNT_W = 2
) (
  input  logic clk_i,
  input  logic sync_rst_i,
  input  logic flush_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic nz_o,
  output logic full_o,
  output logic spur_o
);
  localparam logic [RD_CNT_W-1:0] ONE = RD_CNT_W'(1);

  logic [RD_CNT_W-1:0] cnt;

  assign nz_o   = |cnt;
  assign full_o = &cnt;
  // A same-cycle increment covers a decrement at zero, so only a lone decrement is spurious.
  assign spur_o = dec_i & ~inc_i & ~nz_o;

  always_ff @(posedge clk_i) begin
    if (sync_rst_i || flush_i)
      cnt <= '0;
    else if (inc_i && !dec_i && !full_o)
      cnt <= cnt + ONE;
    else if (dec_i && !inc_i && nz_o)
      cnt <= cnt - ONE;
  end
endmodule

module vproc_hazard_tracker #(
  parameter int unsigned RD_CNT_W = 2
) (
  input  logic        clk_i,
  input  logic        sync_rst_i,
  input  logic        issue_valid_i,
  output logic        issue_ready_o,
  input  logic [31:0] issue_rd_hazards_i,
  input  logic [31:0] issue_wr_hazards_i,
  input  logic [31:0] wr_clr_i,
  input  logic [31:0] rd_clr_i,
  input  logic        flush_i,
  output logic [31:0] pend_wr_o,
  output logic [31:0] pend_rd_o,
  output logic        idle_o,
  output logic        err_o
);
  localparam int unsigned NUM_VREGS = 32;

  logic [NUM_VREGS-1:0] pend_wr;
  logic [NUM_VREGS-1:0] pend_rd;
  logic [NUM_VREGS-1:0] rd_full;
  logic [NUM_VREGS-1:0] spur_rd;
  logic                 err;
  logic                 raw, waw, war, sat, accept;

  // Hazards look only at registered state; same-cycle clears are not bypassed.
  assign raw = |(issue_rd_hazards_i & pend_wr);
  assign waw = |(issue_wr_hazards_i & pend_wr);
  assign war = |(issue_wr_hazards_i & pend_rd);
  assign sat = |(issue_rd_hazards_i & rd_full);

  assign issue_ready_o = ~(raw | waw | war | sat) & ~sync_rst_i & ~flush_i;
  assign accept        = issue_valid_i & issue_ready_o;

  for (genvar n = 0; n < NUM_VREGS; n++) begin : g_vreg
    vproc_hazard_rd_cnt #(.RD_CNT_W(RD_CNT_W)) u_rd_cnt (
      .clk_i      (clk_i),
      .sync_rst_i (sync_rst_i),
      .flush_i    (flush_i),
      .inc_i      (accept & issue_rd_hazards_i[n]),
      .dec_i      (rd_clr_i[n]),
      .nz_o       (pend_rd[n]),
      .full_o     (rd_full[n]),
      .spur_o     (spur_rd[n])
    );
  end

  always_ff @(posedge clk_i) begin
    if (sync_rst_i) begin
      pend_wr <= '0;
      err     <= 1'b0;
    end else if (flush_i) begin
      pend_wr <= '0;
    end else begin
      // Set is applied after clear so a coincident set wins.
      pend_wr <= (pend_wr & ~wr_clr_i) | (accept ? issue_wr_hazards_i : '0);
      if (|(wr_clr_i & ~pend_wr) || |spur_rd)
        err <= 1'b1;
    end
  end

  assign pend_wr_o = pend_wr;
  assign pend_rd_o = pend_rd;
  assign idle_o    = ~|pend_wr & ~|pend_rd;
  assign err_o     = err;
endmodule

// File: tb/tb_vproc_hazard_tracker.sv
// Bench for vproc_hazard_tracker: reference model feeds an expected-state queue
// each cycle; scenario tasks add explicit checks for the key cases.

module tb_vproc_hazard_tracker;
  localparam int RD_CNT_W = 2;
  localparam int CNT_MAX  = (1 << RD_CNT_W) - 1;

  logic        clk = 1'b0;
  logic        sync_rst, issue_valid, issue_ready, flush, idle, err;
  logic [31:0] rd_haz, wr_haz, wr_clr, rd_clr, pend_wr, pend_rd;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pw;
    logic [31:0] pr;
    logic        idle;
    logic        err;
    string       tag;
  } exp_t;

  exp_t sb[$];

  logic [31:0] m_pw = '0;
  int          m_cnt[32];
  logic        m_err = 1'b0;

  always #5 clk = ~clk;

  vproc_hazard_tracker #(.RD_CNT_W(RD_CNT_W)) dut (
    .clk_i              (clk),
    .sync_rst_i         (sync_rst),
    .issue_valid_i      (issue_valid),
    .issue_ready_o      (issue_ready),
    .issue_rd_hazards_i (rd_haz),
    .issue_wr_hazards_i (wr_haz),
    .wr_clr_i           (wr_clr),
    .rd_clr_i           (rd_clr),
    .flush_i            (flush),
    .pend_wr_o          (pend_wr),
    .pend_rd_o          (pend_rd),
    .idle_o             (idle),
    .err_o              (err)
  );

  function automatic logic [31:0] m_pr();
    logic [31:0] r = '0;
    for (int n = 0; n < 32; n++) r[n] = (m_cnt[n] != 0);
    return r;
  endfunction

  function automatic logic m_ready(logic [31:0] rd, logic [31:0] wr, logic fl, logic rs);
    logic ok = !rs && !fl;
    logic [31:0] pr = m_pr();
    for (int n = 0; n < 32; n++) begin
      if (rd[n] && m_pw[n]) ok = 1'b0;
      if (wr[n] && (m_pw[n] || pr[n])) ok = 1'b0;
      if (rd[n] && m_cnt[n] == CNT_MAX) ok = 1'b0;
    end
    return ok;
  endfunction

  // One clock: drive, check ready (model and optional scenario value), advance model, compare state.
  task automatic cyc(input string tag, input logic v, input logic [31:0] rd, input logic [31:0] wr,
                     input logic [31:0] wc, input logic [31:0] rc, input logic fl, input logic rs,
                     input int exp_rdy);
    logic acc;
    exp_t e;
    issue_valid = v; rd_haz = rd; wr_haz = wr; wr_clr = wc; rd_clr = rc; flush = fl; sync_rst = rs;
    #4;
    acc = m_ready(rd, wr, fl, rs);
    checks++;
    if (issue_ready !== acc) begin
      failures++;
      $display("FAIL %s ready(model) got=%b exp=%b", tag, issue_ready, acc);
    end
    if (exp_rdy >= 0) begin
      checks++;
      if (issue_ready !== exp_rdy[0]) begin
        failures++;
        $display("FAIL %s ready got=%b exp=%0d", tag, issue_ready, exp_rdy);
      end
    end
    acc = acc & v;
    if (rs) begin
      m_pw = '0; m_err = 1'b0;
      for (int n = 0; n < 32; n++) m_cnt[n] = 0;
    end else if (fl) begin
      m_pw = '0;
      for (int n = 0; n < 32; n++) m_cnt[n] = 0;
    end else begin
      for (int n = 0; n < 32; n++) begin
        if (wc[n] && !m_pw[n]) m_err = 1'b1;
        if (acc && rd[n] && !rc[n]) m_cnt[n]++;
        else if (rc[n] && !(acc && rd[n])) begin
          if (m_cnt[n] == 0) m_err = 1'b1;
          else m_cnt[n]--;
        end
      end
      m_pw = (m_pw & ~wc) | (acc ? wr : 32'h0);
    end
    e.pw = m_pw; e.pr = m_pr(); e.idle = (m_pw == 0) && (e.pr == 0); e.err = m_err; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    if (pend_wr !== e.pw || pend_rd !== e.pr || idle !== e.idle || err !== e.err) begin
      failures++;
      $display("FAIL %s state got pw=%h pr=%h idle=%b err=%b exp pw=%h pr=%h idle=%b err=%b",
               e.tag, pend_wr, pend_rd, idle, err, e.pw, e.pr, e.idle, e.err);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic test_reset();
    cyc("rst0", 1, 0, 0, 0, 0, 0, 1, 0);
    cyc("rst1", 1, 0, 0, 0, 0, 0, 1, 0);
    cyc("post_rst", 1, 0, 0, 0, 0, 0, 0, 1);
    chk("rst_idle", {pend_wr, pend_rd, 30'h0, idle, err}, {64'h0, 30'h0, 1'b1, 1'b0});
  endtask

  task automatic test_raw();
    cyc("raw_acc", 1, 0, 32'h0000_0F00, 0, 0, 0, 0, 1);
    chk("raw_pw", pend_wr, 32'h0000_0F00);
    cyc("raw_stall", 1, 32'h100, 0, 0, 0, 0, 0, 0);
    cyc("raw_clr_t", 1, 32'h100, 0, 32'h0000_0F00, 0, 0, 0, 0);
    cyc("raw_free_t1", 1, 32'h100, 0, 0, 0, 0, 0, 1);
    chk("raw_rd_pend", pend_rd, 32'h100);
    cyc("raw_drain", 0, 0, 0, 0, 32'h100, 0, 0, -1);
    chk("raw_idle", {31'h0, idle}, 32'h1);
  endtask

  task automatic test_war();
    for (int i = 0; i < 3; i++) cyc("war_rd_acc", 1, 32'h4, 0, 0, 0, 0, 0, 1);
    cyc("war_sat", 1, 32'h4, 0, 0, 0, 0, 0, 0);
    chk("war_pr", pend_rd, 32'h4);
    cyc("war_wr_stall", 1, 0, 32'h4, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc("war_rclr", 1, 0, 32'h4, 0, 32'h4, 0, 0, 0);
      chk("war_pr_drain", pend_rd, (i < 2) ? 32'h4 : 32'h0);
    end
    cyc("war_wr_acc", 1, 0, 32'h4, 0, 0, 0, 0, 1);
    chk("war_pw", pend_wr, 32'h4);
    cyc("war_wclr", 0, 0, 0, 32'h4, 0, 0, 0, -1);
  endtask

  task automatic test_simul();
    cyc("sim_acc", 1, 32'h4, 0, 0, 0, 0, 0, 1);
    cyc("sim_both", 1, 32'h4, 0, 0, 32'h4, 0, 0, 1);
    chk("sim_pr", pend_rd, 32'h4);
    cyc("sim_drain", 0, 0, 0, 0, 32'h4, 0, 0, -1);
    chk("sim_cnt_was_1", pend_rd, 32'h0);
    cyc("sim_zero_both", 1, 32'h8, 0, 0, 32'h8, 0, 0, 1);
    chk("sim_zero_noerr", {pend_rd[3], err}, 32'h0);
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i < 9; i++) cyc("b2b", 1, 0, 32'h1 << i, 0, 0, 0, 0, 1);
    chk("b2b_pw", pend_wr, 32'h0000_01FE);
    cyc("b2b_dep", 1, 32'h2, 0, 0, 0, 0, 0, 0);
    cyc("b2b_clr", 0, 0, 0, 32'h0000_01FE, 0, 0, 0, -1);
  endtask

  task automatic test_spurious();
    cyc("spur", 0, 0, 0, 32'h1, 32'h2, 0, 0, -1);
    chk("spur_err", {31'h0, err}, 32'h1);
    cyc("spur_hold", 0, 0, 0, 0, 0, 0, 0, -1);
    chk("spur_masks", pend_wr | pend_rd, 32'h0);
  endtask

  task automatic test_flush_reset();
    for (int k = 0; k < 2; k++) begin
      cyc("fr_setup0", 1, 32'h1, 32'hFF00_0000, 0, 0, 0, 0, 1);
      cyc("fr_setup1", 1, 32'h1, 0, 0, 0, 0, 0, 1);
      chk("fr_pending", {pend_wr, pend_rd}, {32'hFF00_0000, 32'h1});
      cyc(k == 0 ? "flush" : "mid_rst", 1, 0, 32'h2, 32'hFF00_0000, 32'h1, k == 0, k == 1, 0);
      chk("fr_idle", {31'h0, idle}, 32'h1);
      chk("fr_err", {31'h0, err}, (k == 0) ? 32'h1 : 32'h0);
    end
  endtask

  initial begin
    for (int n = 0; n < 32; n++) m_cnt[n] = 0;
    test_reset();
    test_raw();
    test_war();
    test_simul();
    test_back_to_back();
    test_spurious();
    test_flush_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
